// File: rtl/fetch_stage.sv
// fetch_stage
// -----------
// Instruction-fetch stage sitting directly in front of the decoder.
// Holds the program counter, issues one sequential word read per cycle to a
// synchronous instruction memory with a fixed one-cycle read latency, and
// presents the fetched word through an IF/ID output register.
// A one-entry skid buffer absorbs the single response that can still be in
// flight when decode stalls. A redirect from execute flushes everything and
// restarts fetch at the new target.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous active-high reset, overrides everything
//   imem_req     read request this cycle (memory always accepts)
//   imem_addr    word-aligned read address, always equal to the PC register
//   imem_rdata   read data, valid exactly one cycle after an accepted request
//   stall        decode cannot accept, hold the output register
//   redirect_en  flush the pipeline and restart fetch at redirect_pc
//   redirect_pc  new fetch target, low two bits are ignored
//   instr        registered instruction to the decoder (NOP_INSTR when invalid)
//   instr_pc     address of instr
//   instr_valid  instr/instr_pc hold a live instruction

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    logic [31:0] pc_q;

    logic        inflight_q;
    logic [31:0] inflight_pc_q;

    logic        skid_valid_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;

    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_q;

    logic        adv;
    logic [31:0] redirect_target;

    // Control decode for the whole stage.
    // The output register may advance unless it holds a live instruction that
    // decode is refusing. A new request is withheld whenever the skid is
    // occupied, or when a response is already in flight into a stalled,
    // occupied output register: that response is about to fill the skid, so
    // a second one would have nowhere to go. This is what keeps the one-entry
    // skid from ever overflowing.
    always_comb begin
        adv             = 1'b1;
        imem_req        = 1'b0;
        redirect_target = 32'h0000_0000;

        adv             = !(out_valid_q && stall);
        imem_req        = !rst && !redirect_en && !skid_valid_q
                          && !(inflight_q && out_valid_q && stall);
        redirect_target = redirect_pc & ~32'h0000_0003;
    end

    // Program counter.
    // Advances by one word for every issued request and wraps naturally at
    // the top of the 32-bit address space. A redirect loads the word-aligned
    // target; in that cycle no request goes out, so the first read at the new
    // target is issued on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_en) begin
            pc_q <= redirect_target;
        end else if (imem_req) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    // In-flight tracker.
    // Remembers that the memory will return data next cycle and which address
    // that data belongs to. Because no request is issued during reset or a
    // redirect, this also discards the response of any request made before a
    // flush: the returning word arrives with inflight_q already cleared and is
    // simply ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    // Skid buffer.
    // Catches the response that lands while the output register is held by a
    // stall. Once the output register can advance again the skid entry is the
    // oldest instruction, so it drains first and the entry is freed. While the
    // skid is full no request is issued, so a response can never coincide with
    // a skid drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0000_0000;
            skid_pc_q    <= 32'h0000_0000;
        end else if (redirect_en) begin
            skid_valid_q <= 1'b0;
        end else if (adv) begin
            skid_valid_q <= 1'b0;
        end else if (inflight_q) begin
            skid_valid_q <= 1'b1;
            skid_instr_q <= imem_rdata;
            skid_pc_q    <= inflight_pc_q;
        end
    end

    // IF/ID output register.
    // On advance it takes, in strict age order, the skid entry, else the
    // memory response, else goes empty and parks the NOP encoding on instr so
    // the decoder never sees stale data. An empty register always advances,
    // which is why a stall while nothing is valid has no effect. A redirect
    // kills the current instruction even if decode is stalling, since that
    // instruction belongs to the abandoned stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= 32'h0000_0000;
        end else if (redirect_en) begin
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
        end else if (adv) begin
            if (skid_valid_q) begin
                out_valid_q <= 1'b1;
                out_instr_q <= skid_instr_q;
                out_pc_q    <= skid_pc_q;
            end else if (inflight_q) begin
                out_valid_q <= 1'b1;
                out_instr_q <= imem_rdata;
                out_pc_q    <= inflight_pc_q;
            end else begin
                out_valid_q <= 1'b0;
                out_instr_q <= NOP_INSTR;
            end
        end
    end

    // Output drive.
    // The memory address is the PC register itself; the decoder-facing
    // signals come straight from the output register.
    always_comb begin
        imem_addr   = pc_q;
        instr       = out_instr_q;
        instr_pc    = out_pc_q;
        instr_valid = out_valid_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// --------------
// Directed self-checking bench for fetch_stage.
// A small instruction memory returns a word derived from its address one
// cycle after each request, and garbage otherwise. A linear sequence of
// directed steps drives reset, stall and redirect and checks the per-cycle
// request/address/output behaviour. A scoreboard queue holds the addresses
// that decode is expected to accept, in order; a monitor pops and compares
// every instruction that decode actually accepts.
//
// Ports: none (top-level bench).

module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] mon_pc;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    // Contents of the instruction memory: a fixed function of the address so
    // every expected instruction word can be recomputed from its PC.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory with one-cycle latency. Data bus carries
    // a recognisable junk value in cycles with no response due.
    always @(posedge clk) begin
        if (imem_req === 1'b1) begin
            imem_rdata <= memf(imem_addr);
        end else begin
            imem_rdata <= 32'hBAD0_BAD0;
        end
    end

    // Scoreboard consumer: every instruction decode accepts (valid, not
    // stalled, not flushed by redirect or reset) must be the next expected one.
    always @(negedge clk) begin
        if (rst === 1'b0 && redirect_en === 1'b0 && stall === 1'b0 && instr_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_instr observed pc=%h expected=none", instr_pc);
            end
            if (exp_q.size() > 0) begin
                mon_pc = exp_q.pop_front();
                checks++;
                assert (instr_pc === mon_pc) else begin
                    errors++;
                    $error("[TB] FAIL sb_pc observed=%h expected=%h", instr_pc, mon_pc);
                end
                checks++;
                assert (instr === memf(mon_pc)) else begin
                    errors++;
                    $error("[TB] FAIL sb_instr observed=%h expected=%h", instr, memf(mon_pc));
                end
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic re,
                                 input logic [31:0] rp);
        @(posedge clk);
        #1;
        rst         = r;
        stall       = s;
        redirect_en = re;
        redirect_pc = rp;
    endtask

    // Check the cycle's outputs on the falling edge.
    task automatic checkOutput(input string tag, input logic exp_req,
                               input logic [31:0] exp_addr, input logic exp_valid,
                               input logic [31:0] exp_pc, input logic chk_pc);
        logic [31:0] exp_instr;
        @(negedge clk);
        exp_instr = exp_valid ? memf(exp_pc) : NOP_INSTR;
        checks++;
        assert (imem_req === exp_req) else begin
            errors++;
            $error("[TB] FAIL %s imem_req observed=%0b expected=%0b", tag, imem_req, exp_req);
        end
        checks++;
        assert (imem_addr === exp_addr) else begin
            errors++;
            $error("[TB] FAIL %s imem_addr observed=%h expected=%h", tag, imem_addr, exp_addr);
        end
        checks++;
        assert (instr_valid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL %s instr_valid observed=%0b expected=%0b", tag, instr_valid, exp_valid);
        end
        checks++;
        assert (instr === exp_instr) else begin
            errors++;
            $error("[TB] FAIL %s instr observed=%h expected=%h", tag, instr, exp_instr);
        end
        if (chk_pc || exp_valid) begin
            checks++;
            assert (instr_pc === exp_pc) else begin
                errors++;
                $error("[TB] FAIL %s instr_pc observed=%h expected=%h", tag, instr_pc, exp_pc);
            end
        end
    endtask

    // Directed sequence.
    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        $display("[TB] start");

        applyStimulus(1, 0, 0, 32'h0); checkOutput("reset_a", 0, RESET_PC, 0, 32'h0, 1);
        applyStimulus(1, 0, 0, 32'h0); checkOutput("reset_b", 0, RESET_PC, 0, 32'h0, 1);

        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("run_r0", 1, 32'h0,  0, 32'h0, 1);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("run_r1", 1, 32'h4,  0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("run_r2", 1, 32'h8,  1, 32'h0, 1);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("run_r3", 1, 32'hC,  1, 32'h4, 1);

        applyStimulus(0, 1, 0, 32'h0); checkOutput("stall_1", 0, 32'h10, 1, 32'h8, 1);
        applyStimulus(0, 1, 0, 32'h0); checkOutput("stall_2", 0, 32'h10, 1, 32'h8, 1);
        applyStimulus(0, 1, 0, 32'h0); checkOutput("stall_3", 0, 32'h10, 1, 32'h8, 1);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("release", 0, 32'h10, 1, 32'h8, 1);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("drain_c", 1, 32'h10, 1, 32'hC, 1);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("refill",  1, 32'h14, 0, 32'h0, 0);

        applyStimulus(0, 1, 0, 32'h0);   checkOutput("skid_fill", 0, 32'h18, 1, 32'h10, 1);
        applyStimulus(0, 1, 1, 32'h100); checkOutput("redir_100", 0, 32'h18, 1, 32'h10, 1);
        exp_q.push_back(32'h100);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("redir_r1", 1, 32'h100, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("redir_r2", 1, 32'h104, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("redir_r3", 1, 32'h108, 1, 32'h100, 1);

        applyStimulus(0, 1, 1, 32'h203); checkOutput("redir_stall", 0, 32'h10C, 1, 32'h104, 1);
        exp_q.push_back(32'h200);
        applyStimulus(0, 1, 0, 32'h0); checkOutput("empty_stall1", 1, 32'h200, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 32'h0); checkOutput("empty_stall2", 1, 32'h204, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("resume_200",   1, 32'h208, 1, 32'h200, 1);

        applyStimulus(0, 0, 1, 32'hFFFF_FFF8); checkOutput("redir_wrap", 0, 32'h20C, 1, 32'h204, 1);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("wrap_r1", 1, 32'hFFFF_FFF8, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("wrap_r2", 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("wrap_r3", 1, 32'h0000_0000, 1, 32'hFFFF_FFF8, 1);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("wrap_r4", 1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 1);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("wrap_r5", 1, 32'h0000_0008, 1, 32'h0000_0000, 1);

        applyStimulus(0, 1, 0, 32'h0); checkOutput("pre_rst_skid", 0, 32'hC, 1, 32'h4, 1);
        applyStimulus(1, 1, 0, 32'h0); checkOutput("mid_rst_a",    0, 32'hC, 1, 32'h4, 1);
        applyStimulus(1, 0, 0, 32'h0); checkOutput("mid_rst_b",    0, RESET_PC, 0, 32'h0, 1);

        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("restart_r0", 1, 32'h0,  0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("restart_r1", 1, 32'h4,  0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("restart_r2", 1, 32'h8,  1, 32'h0, 1);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("restart_r3", 1, 32'hC,  1, 32'h4, 1);
        applyStimulus(0, 0, 0, 32'h0); checkOutput("restart_r4", 1, 32'h10, 1, 32'h8, 1);

        applyStimulus(0, 1, 0, 32'h0);
        @(negedge clk);
        #1;
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("[TB] FAIL sb_drained observed=%0d left expected=0 left", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
